oai_reduce_pipe: RTL

Parametrised, pipelined successor to the fixed 2x2 OR-AND-INVERT cell. It evaluates GROUPS groups of FANIN terms across WIDTH independent bit lanes, with a per-transaction mode select:
- OAI: Y = ~AND(OR(group))
- AOI: Y = ~OR(AND(group))

Results pass through a 2-stage valid/ready pipeline and carry a popcount of the result. It is used in datapath zero-detect, compare and flag logic where one cell instance per bit is not practical.

---
 rtl/rv523_cell_pkg.sv | 11 +
 rtl/oai_reduce_pipe_reduce_lane.sv | 30 +++
 rtl/oai_reduce_pipe.sv | 111 +++++++++++
 3 files changed

// File: rtl/rv523_cell_pkg.sv
// rtl/rv523_cell_pkg.sv - shared mode encodings and width helper for the reduce cells
package rv523_cell_pkg;

    localparam logic MODE_OAI = 1'b0;
    localparam logic MODE_AOI = 1'b1;

    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/oai_reduce_pipe_reduce_lane.sv
// rtl/oai_reduce_pipe_reduce_lane.sv - one lane of the two-level OAI/AOI reduction
// The first level feeds the stage-1 register and the second level reads it back.
module reduce_lane
    import rv523_cell_pkg::*;
#(
    parameter int GROUPS = 2,
    parameter int FANIN  = 2
) (
    input  logic                    i_s1_mode,
    input  logic [GROUPS*FANIN-1:0] i_terms,
    output logic [GROUPS-1:0]       o_p,
    input  logic                    i_s2_mode,
    input  logic [GROUPS-1:0]       i_p,
    output logic                    o_y
);

    always_comb begin
        o_p = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (i_s1_mode == MODE_AOI) begin
                o_p[g] = &i_terms[g*FANIN +: FANIN];
            end else begin
                o_p[g] = |i_terms[g*FANIN +: FANIN];
            end
        end
    end

    assign o_y = (i_s2_mode == MODE_AOI) ? ~(|i_p) : ~(&i_p);

endmodule

// File: rtl/oai_reduce_pipe.sv
// rtl/oai_reduce_pipe.sv - pipelined GROUPS x FANIN OAI/AOI reducer over WIDTH lanes
// Two valid/ready stages; the result is registered together with its popcount and flags.
module oai_reduce_pipe
    import rv523_cell_pkg::*;
#(
    parameter  int GROUPS = 2,
    parameter  int FANIN  = 2,
    parameter  int WIDTH  = 8,
    localparam int CW     = count_width(WIDTH)
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    input  logic                          IN_MODE,
    input  logic [GROUPS*FANIN*WIDTH-1:0] IN_DATA,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [WIDTH-1:0]              OUT_Y,
    output logic [CW-1:0]                 OUT_COUNT,
    output logic                          OUT_ALL,
    output logic                          OUT_NONE
);

    localparam int TERMS = GROUPS * FANIN;

    logic [TERMS-1:0]             w_terms [WIDTH];
    logic [WIDTH-1:0][GROUPS-1:0] w_p;
    logic [WIDTH-1:0]             w_y;
    logic [CW-1:0]                w_count;
    logic                         w_adv1;
    logic                         w_adv2;

    logic                         r_s1_valid;
    logic                         r_s1_mode;
    logic [WIDTH-1:0][GROUPS-1:0] r_s1_p;
    logic                         r_s2_valid;
    logic [WIDTH-1:0]             r_y;
    logic [CW-1:0]                r_count;
    logic                         r_all;
    logic                         r_none;

    // IN_DATA is term-major; regroup it so each lane sees its own term vector.
    for (genvar l = 0; l < WIDTH; l++) begin : g_lane
        for (genvar k = 0; k < TERMS; k++) begin : g_term
            assign w_terms[l][k] = IN_DATA[k*WIDTH + l];
        end

        reduce_lane #(
            .GROUPS (GROUPS),
            .FANIN  (FANIN)
        ) u_reduce_lane (
            .i_s1_mode (IN_MODE),
            .i_terms   (w_terms[l]),
            .o_p       (w_p[l]),
            .i_s2_mode (r_s1_mode),
            .i_p       (r_s1_p[l]),
            .o_y       (w_y[l])
        );
    end

    always_comb begin
        w_count = '0;
        for (int l = 0; l < WIDTH; l++) begin
            w_count = w_count + CW'(w_y[l]);
        end
    end

    assign w_adv2   = !r_s2_valid || OUT_READY;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign IN_READY = w_adv1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= MODE_OAI;
            r_s1_p     <= '0;
            r_s2_valid <= 1'b0;
            r_y        <= '0;
            r_count    <= '0;
            r_all      <= 1'b0;
            r_none     <= 1'b1;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= IN_VALID;
                if (IN_VALID) begin
                    r_s1_mode <= IN_MODE;
                    r_s1_p    <= w_p;
                end
            end
            // Data registers only load real transactions, so a bubble leaves
            // OUT_VALID low rather than replaying the previous result.
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_y     <= w_y;
                    r_count <= w_count;
                    r_all   <= &w_y;
                    r_none  <= ~(|w_y);
                end
            end
        end
    end

    assign OUT_VALID = r_s2_valid;
    assign OUT_Y     = r_y;
    assign OUT_COUNT = r_count;
    assign OUT_ALL   = r_all;
    assign OUT_NONE  = r_none;

endmodule
